// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master sequencer.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TRAIL = 3'd4
  } spi_state_e;

  localparam int LEN_DATA_DEF   = 8;
  localparam int NUM_SLAVES_DEF = 4;
  localparam int SS_MAX         = 64;

  // Deselected SS bus; callers slice the low NUM_SLAVES bits (NUM_SLAVES <= SS_MAX).
  function automatic logic [SS_MAX-1:0] ss_idle();
    return {SS_MAX{1'b1}};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: tick marks the last CLK cycle of each half-period.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  // Tick decode and wrap/clear of the divider count
  always_comb begin
    tick = (div_cnt_q == DIV_MAX);
    if (clr || tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Divider count register
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-master SPI sequencer (SCLK idles low, LSB first, slaves act on SCLK fall).
// Optional build macro SPI_LOOPBACK_EN adds a LOOPBACK input that routes MOSI into the rx shifter.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int LEN_DATA   = LEN_DATA_DEF,
  parameter int NUM_SLAVES = NUM_SLAVES_DEF,
  parameter int CLK_DIV    = 2,
  localparam int SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [SEL_W-1:0]      SLAVE_SEL,
  input  logic [LEN_DATA-1:0]   TX_DATA,
  output logic [LEN_DATA-1:0]   RX_DATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO,
`ifdef SPI_LOOPBACK_EN
  input  logic                  LOOPBACK,
`endif
  output logic [NUM_SLAVES-1:0] SS
);

  localparam int BIT_W = $clog2(LEN_DATA + 1);
  localparam logic [BIT_W-1:0]      LEN_CNT = BIT_W'(LEN_DATA);
  localparam logic [SEL_W:0]        NS_LIM  = (SEL_W + 1)'(NUM_SLAVES);
  localparam logic [SS_MAX-1:0]     SS_ALL  = ss_idle();
  localparam logic [NUM_SLAVES-1:0] SS_IDLE = SS_ALL[NUM_SLAVES-1:0];
  localparam logic [NUM_SLAVES-1:0] SS_ONE  = NUM_SLAVES'(1'b1);

  spi_state_e state_q, state_d;
  logic [LEN_DATA-1:0]   tx_q, tx_d;
  logic [LEN_DATA-1:0]   rx_q, rx_d;
  logic [LEN_DATA-1:0]   rx_data_q, rx_data_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [NUM_SLAVES-1:0] ss_q, ss_d;
  logic sclk_q, sclk_d;
  logic mosi_q, mosi_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
`ifdef SPI_LOOPBACK_EN
  logic lb_q, lb_d;
`endif
  logic tick_s;
  logic clr_s;
  logic sel_ok_s;
  logic rx_in_s;

  // The divider restarts at every state change, so each phase lasts exactly CLK_DIV cycles
  assign clr_s    = (state_d != state_q);
  assign sel_ok_s = ({1'b0, SLAVE_SEL} < NS_LIM);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (CLK),
    .rst  (RST),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Next-state and datapath decode
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    ss_d      = ss_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef SPI_LOOPBACK_EN
    lb_d      = lb_q;
    rx_in_s   = lb_q ? mosi_q : MISO;
`else
    rx_in_s   = MISO;
`endif
    case (state_q)
      IDLE: begin
        if (START && sel_ok_s) begin
          state_d   = LEAD;
          tx_d      = TX_DATA;
          mosi_d    = TX_DATA[0];
          bit_cnt_d = '0;
          busy_d    = 1'b1;
`ifdef SPI_LOOPBACK_EN
          lb_d      = LOOPBACK;
          if (LOOPBACK) begin
            ss_d = SS_IDLE;
          end else begin
            ss_d = ~(SS_ONE << SLAVE_SEL);
          end
`else
          ss_d      = ~(SS_ONE << SLAVE_SEL);
`endif
        end else if (START) begin
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
        end
      end
      LEAD: begin
        if (tick_s) begin
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          state_d = LEAD;
        end
      end
      HIGH: begin
        if (tick_s) begin
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          state_d   = LOW;
        end else begin
          state_d = HIGH;
        end
      end
      LOW: begin
        if (tick_s) begin
          rx_d = LEN_DATA'({rx_in_s, rx_q} >> 1);
          if (bit_cnt_q == LEN_CNT) begin
            state_d = TRAIL;
          end else begin
            // MOSI moves only on the rising edge, a full half-period ahead of the slave's sample
            tx_d    = tx_q >> 1;
            mosi_d  = tx_d[0];
            sclk_d  = 1'b1;
            state_d = HIGH;
          end
        end else begin
          state_d = LOW;
        end
      end
      TRAIL: begin
        if (tick_s) begin
          ss_d      = SS_IDLE;
          rx_data_d = rx_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = TRAIL;
        end
      end
      default: begin
        state_d = IDLE;
        ss_d    = SS_IDLE;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      ss_q      <= SS_IDLE;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      lb_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      ss_q      <= ss_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef SPI_LOOPBACK_EN
      lb_q      <= lb_d;
`endif
    end
  end

  assign RX_DATA = rx_data_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SS      = ss_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: timeline model + SPI slave model + directed literal checks.
module tb_spi_master_ctrl;

  localparam int LEN   = 8;
  localparam int NS    = 4;
  localparam int DIV   = 2;
  localparam int TOTAL = DIV * (2 * LEN + 2);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [7:0] tx = 8'h00;
  logic       lb = 1'b0;
  logic [7:0] rx;
  logic       busy, done, err, sclk, mosi, miso;
  logic [3:0] ss;

  logic       start5 = 1'b0;
  logic [2:0] sel5 = 3'd0;
  logic [7:0] tx5 = 8'h00;
  logic [7:0] rx5;
  logic       busy5, done5, err5, sclk5, mosi5;
  logic [4:0] ss5;

  always #5 clk = ~clk;

  spi_master_ctrl u_dut (
    .CLK(clk), .RST(rst), .START(start), .SLAVE_SEL(sel), .TX_DATA(tx),
    .RX_DATA(rx), .BUSY(busy), .DONE(done), .ERR(err), .SCLK(sclk),
    .MOSI(mosi), .MISO(miso),
`ifdef SPI_LOOPBACK_EN
    .LOOPBACK(lb),
`endif
    .SS(ss)
  );

  // Five-slave instance so that an out-of-range select is representable
  spi_master_ctrl #(.NUM_SLAVES(5)) u_dut5 (
    .CLK(clk), .RST(rst), .START(start5), .SLAVE_SEL(sel5), .TX_DATA(tx5),
    .RX_DATA(rx5), .BUSY(busy5), .DONE(done5), .ERR(err5), .SCLK(sclk5),
    .MOSI(mosi5), .MISO(1'b0),
`ifdef SPI_LOOPBACK_EN
    .LOOPBACK(1'b0),
`endif
    .SS(ss5)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SPI slave: on each SCLK fall presents its next LSB and shifts MOSI in at the top
  logic [7:0] slave_sr;
  logic [7:0] slave_pre = 8'h00;
  logic       slave_go = 1'b0;
  always @(negedge sclk or posedge slave_go) begin
    if (slave_go) slave_sr <= slave_pre;
    else if (ss !== 4'hF) begin
      miso     <= slave_sr[0];
      slave_sr <= {mosi, slave_sr[7:1]};
    end
  end

  task automatic load_slave(input logic [7:0] v);
    slave_pre = v;
    slave_go = 1'b1;
    #1 slave_go = 1'b0;
  endtask

  // MOSI/SS as seen at each SCLK fall
  logic       cap_mosi [8];
  logic [3:0] cap_ss [8];
  int         cap_n = 8;
  initial forever begin
    @(negedge sclk);
    if (cap_n < 8) begin
      cap_mosi[cap_n] = mosi;
      cap_ss[cap_n] = ss;
      cap_n++;
    end
  end

  // Timeline model: m_cnt is cycles since the accept edge (-1 idle, TOTAL = DONE cycle)
  int         m_cnt = -1;
  int         m_sel = 0;
  logic [7:0] m_tx = 8'h00;
  logic       m_lb = 1'b0;
  logic [7:0] m_exp_rx = 8'h00;
  logic [7:0] m_rx = 8'h00;
  logic       m_err = 1'b0;
  logic       m_mosi_idle = 1'b0;
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_cnt = -1; m_rx = 8'h00; m_err = 1'b0; m_mosi_idle = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_cnt >= 0 && m_cnt < TOTAL) begin
        m_cnt++;
        if (m_cnt == TOTAL) begin
          m_rx = m_exp_rx;
          m_mosi_idle = m_tx[LEN-1];
        end
      end else if (start) begin
        if (int'(sel) < NS) begin
          m_cnt = 0; m_sel = int'(sel); m_tx = tx;
`ifdef SPI_LOOPBACK_EN
          m_lb = lb;
`else
          m_lb = 1'b0;
`endif
          m_exp_rx = m_lb ? tx : slave_sr;
        end else begin
          m_cnt = -1; m_err = 1'b1;
        end
      end else begin
        m_cnt = -1;
      end
    end
  end

  task automatic compare_cycle();
    logic [3:0] ss_e;
    logic sclk_e, mosi_e, busy_e, done_e;
    int ph, bi;
    busy_e = (m_cnt >= 0 && m_cnt < TOTAL);
    done_e = (m_cnt == TOTAL);
    if (busy_e) begin
      ph = m_cnt / DIV;
      sclk_e = (ph % 2 == 1) && (ph <= 2 * LEN);
      bi = (ph == 0) ? 0 : (ph - 1) / 2;
      if (bi > LEN - 1) bi = LEN - 1;
      mosi_e = m_tx[bi];
      ss_e = m_lb ? 4'hF : ~(4'b0001 << m_sel);
    end else begin
      sclk_e = 1'b0;
      mosi_e = m_mosi_idle;
      ss_e = 4'hF;
    end
    check("cyc_sclk", sclk, sclk_e);
    check("cyc_mosi", mosi, mosi_e);
    check("cyc_ss", ss, ss_e);
    check("cyc_busy", busy, busy_e);
    check("cyc_done", done, done_e);
    check("cyc_err", err, m_err);
    check("cyc_rx", rx, m_rx);
  endtask

  initial forever begin
    @(negedge clk);
    if (cmp_en) compare_cycle();
  end

  task automatic start_xfer(input logic [1:0] s, input logic [7:0] t, input logic l, output int a);
    @(posedge clk); #1;
    start = 1'b1; sel = s; tx = t; lb = l;
    @(posedge clk); #1;
    a = cyc; start = 1'b0;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int n = 0; n < 200 && at < 0; n++) begin
      @(negedge clk);
      if (done) at = cyc;
    end
    if (at < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  int fall_exp [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  initial begin
    int a, d, d1, d2, rises, seen;
    logic prev;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    check("rst_ss", ss, 4'hF);
    check("rst_sclk", sclk, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx", rx, 8'h00);
    @(posedge clk); #1 rst = 1'b0;

    // Basic transfer
    load_slave(8'h3F);
    cap_n = 0;
    start_xfer(2'd0, 8'hA5, 1'b0, a);
    wait_done(d);
    check("latency", d - a, 32'd36);
    check("rx_basic", rx, 8'h3F);
    for (int i = 0; i < 8; i++) begin
      check("mosi_fall", cap_mosi[i], fall_exp[i]);
      check("ss_fall_s0", cap_ss[i], 4'b1110);
    end

    // Echo of previous TX
    start_xfer(2'd0, 8'h00, 1'b0, a);
    wait_done(d);
    check("rx_echo", rx, 8'hA5);

    // Slave 3 select
    cap_n = 0;
    start_xfer(2'd3, 8'h5A, 1'b0, a);
    wait_done(d);
    check("rx_sel3", rx, 8'h00);
    for (int i = 0; i < 8; i++) check("ss_fall_s3", cap_ss[i], 4'b0111);

    // Back-to-back with START held high throughout
    @(posedge clk); #1;
    start = 1'b1; sel = 2'd1; tx = 8'h11;
    @(posedge clk); #1;
    tx = 8'h22;
    wait_done(d1);
    check("b2b_ss_gap", ss, 4'hF);
    check("b2b_rx1", rx, 8'h5A);
    @(posedge clk); #1 start = 1'b0;
    wait_done(d2);
    check("b2b_spacing", d2 - d1, 32'd37);
    check("b2b_rx2", rx, 8'h11);

    // Reset abort at the third SCLK rise
    start_xfer(2'd2, 8'hFF, 1'b0, a);
    rises = 0;
    prev = sclk;
    for (int n = 0; n < 100 && rises < 3; n++) begin
      @(negedge clk);
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    check("abort_rises", rises, 32'd3);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ss", ss, 4'hF);
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_rx", rx, 8'h00);
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", seen, 32'd0);

`ifdef SPI_LOOPBACK_EN
    cap_n = 0;
    start_xfer(2'd2, 8'hC3, 1'b1, a);
    wait_done(d);
    check("lb_rx", rx, 8'hC3);
    for (int i = 0; i < 8; i++) check("lb_ss", cap_ss[i], 4'hF);
    lb = 1'b0;
`endif

    // Out-of-range select on the five-slave instance
    @(posedge clk); #1;
    start5 = 1'b1; sel5 = 3'd5; tx5 = 8'h77;
    @(posedge clk); #1 start5 = 1'b0;
    @(negedge clk);
    check("err5_pulse", err5, 1'b1);
    check("err5_busy", busy5, 1'b0);
    check("err5_ss", ss5, 5'h1F);
    check("err5_done", done5, 1'b0);
    @(negedge clk);
    check("err5_one_cycle", err5, 1'b0);
    @(posedge clk); #1;
    start5 = 1'b1; sel5 = 3'd4;
    @(posedge clk); #1 start5 = 1'b0;
    @(negedge clk);
    check("sel4_busy", busy5, 1'b1);
    check("sel4_ss", ss5, 5'b01111);
    check("sel4_err", err5, 1'b0);
    seen = 0;
    for (int n = 0; n < 200 && seen == 0; n++) begin
      @(negedge clk);
      if (done5) seen = 1;
    end
    check("sel4_done", seen, 32'd1);
    check("sel4_done_err", err5, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
